// File: rtl/integer_log_pkg.sv
// Shared types and constants for the integer logarithm block: state encoding,
// operand widths and active-low 7-segment patterns (gfedcba).
package integer_log_pkg;

    localparam int unsigned P_W   = 15;
    localparam int unsigned X_W   = 4;
    localparam int unsigned A_W   = 4;
    localparam int unsigned ACC_W = P_W + X_W;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CALC   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Index 9 is the leftmost element of the concatenation
    localparam logic [9:0][SEG_W-1:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/integer_log_if.sv
// Key/switch inputs and result/display outputs of the integer logarithm block.
interface integer_log_if;
    import integer_log_pkg::*;

    logic             i_load;
    logic             i_start;
    logic [P_W-1:0]   i_P;
    logic [X_W-1:0]   i_X;
    logic             o_done;
    logic [A_W-1:0]   o_A;
    logic             o_exact;
    logic             o_err;
    logic [SEG_W-1:0] seg_i_X_ten;
    logic [SEG_W-1:0] seg_i_X_unit;
    logic [SEG_W-1:0] seg_o_A_ten;
    logic [SEG_W-1:0] seg_o_A_unit;

    modport master (
        output i_load, i_start, i_P, i_X,
        input  o_done, o_A, o_exact, o_err,
        input  seg_i_X_ten, seg_i_X_unit, seg_o_A_ten, seg_o_A_unit
    );

    modport slave (
        input  i_load, i_start, i_P, i_X,
        output o_done, o_A, o_exact, o_err,
        output seg_i_X_ten, seg_i_X_unit, seg_o_A_ten, seg_o_A_unit
    );

endinterface

// File: rtl/integer_log_seg7_decoder.sv
// Decimal digit to active-low 7-segment pattern; out-of-range digits show "0".
module seg7_decoder
    import integer_log_pkg::*;
(
    input  logic [3:0]       digit_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DIGIT[0];
        if (digit_i < 4'd10) begin
            seg_o = SEG_DIGIT[digit_i];
        end
    end

endmodule

// File: rtl/integer_log.sv
// Smallest A with X^A >= P by repeated multiply-and-compare, one step per clock,
// with decimal 7-segment readout of the latched base and the result.
module integer_log
    import integer_log_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    integer_log_if.slave bus
);

    state_e           state_q;
    logic [P_W-1:0]   reg_p_q;
    logic [X_W-1:0]   reg_x_q;
    logic [ACC_W-1:0] acc_q;
    logic [A_W-1:0]   cnt_q;
    logic             done_q;
    logic [A_W-1:0]   a_q;
    logic             exact_q;
    logic             err_q;

    logic             op_err_c;
    logic [ACC_W-1:0] p_ext_c;

    assign p_ext_c  = ACC_W'(reg_p_q);
    // Zero operands and base 1 with P != 1 never reach P
    assign op_err_c = (reg_p_q == '0) || (reg_x_q == '0) ||
                      ((reg_x_q == X_W'(1)) && (reg_p_q != P_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            reg_p_q <= '0;
            reg_x_q <= '0;
            acc_q   <= ACC_W'(1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_q  <= ACC_W'(1);
                    cnt_q  <= '0;
                    done_q <= 1'b0;
                    if (!bus.i_load) begin
                        reg_p_q <= bus.i_P;
                        reg_x_q <= bus.i_X;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!bus.i_start) begin
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (op_err_c) begin
                        err_q   <= 1'b1;
                        a_q     <= '0;
                        exact_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (acc_q >= p_ext_c) begin
                        a_q     <= cnt_q;
                        exact_q <= (acc_q == p_ext_c);
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        // acc < 2^P_W here, so the product fits ACC_W bits
                        acc_q <= ACC_W'(acc_q * ACC_W'(reg_x_q));
                        cnt_q <= cnt_q + A_W'(1);
                    end
                end
                ST_FINISH: begin
                    if (!bus.i_load) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_done  = done_q;
    assign bus.o_A     = a_q;
    assign bus.o_exact = exact_q;
    assign bus.o_err   = err_q;

    logic [3:0]       x_ten_c, x_unit_c, a_ten_c, a_unit_c;
    logic [SEG_W-1:0] a_ten_seg_c, a_unit_seg_c;

    assign x_ten_c  = 4'(reg_x_q / X_W'(10));
    assign x_unit_c = 4'(reg_x_q % X_W'(10));
    assign a_ten_c  = 4'(a_q / A_W'(10));
    assign a_unit_c = 4'(a_q % A_W'(10));

    seg7_decoder u_seg_x_ten  (.digit_i(x_ten_c),  .seg_o(bus.seg_i_X_ten));
    seg7_decoder u_seg_x_unit (.digit_i(x_unit_c), .seg_o(bus.seg_i_X_unit));
    seg7_decoder u_seg_a_ten  (.digit_i(a_ten_c),  .seg_o(a_ten_seg_c));
    seg7_decoder u_seg_a_unit (.digit_i(a_unit_c), .seg_o(a_unit_seg_c));

    assign bus.seg_o_A_ten  = err_q ? SEG_DASH : a_ten_seg_c;
    assign bus.seg_o_A_unit = err_q ? SEG_DASH : a_unit_seg_c;

endmodule
